segre_rollback_unit: RTL and testbench

Consumer side of the history-file recovery stream. While the history file is recovering, it presents one saved entry per cycle: destination register, old value and pc, youngest first. This block writes each entry back into the register file and holds the pipeline flushed. Once the stream drains, it redirects fetch to the trap vector and records the excepting pc.

---
 rtl/segre_rollback_unit.sv | 153 +++++++++++++++
 tb/tb_segre_rollback_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_rollback_unit.sv
// Rollback consumer for the history-file recovery stream: restores saved register
// values, holds the pipeline flushed, then redirects fetch to the trap vector.
module segre_rollback_unit #(
  parameter int REG_SIZE  = 5,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 recovering_i,
  input  logic                 hf_empty_i,
  input  logic [REG_SIZE-1:0]  dest_reg_i,
  input  logic [WORD_SIZE-1:0] value_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  input  logic [ADDR_SIZE-1:0] mtvec_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 flush_o,
  output logic                 redirect_o,
  output logic [ADDR_SIZE-1:0] redirect_pc_o,
  output logic [ADDR_SIZE-1:0] epc_o,
  output logic [3:0]           rollback_count_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROLLBACK = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_SIZE-1:0]  rf_waddr_q, rf_waddr_d;
  logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic                 flush_q, flush_d;
  logic                 redirect_q, redirect_d;
  logic [ADDR_SIZE-1:0] redirect_pc_q, redirect_pc_d;
  logic [ADDR_SIZE-1:0] epc_q, epc_d;
  logic [3:0]           count_q, count_d;
  logic [3:0]           count_base_s;
  logic                 busy_q, busy_d;
  logic                 consume_s;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    consume_s     = 1'b0;
    count_base_s  = count_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    count_d       = count_q;

    case (state_q)
      IDLE: begin
        if (recovering_i) begin
          state_d = ROLLBACK;
        end else begin
          state_d = IDLE;
        end
      end
      ROLLBACK: begin
        if (hf_empty_i || !recovering_i) begin
          state_d = REDIRECT;
        end else begin
          state_d = ROLLBACK;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if ((state_q == IDLE) || (state_q == ROLLBACK)) begin
      consume_s = recovering_i && !hf_empty_i;
    end else begin
      consume_s = 1'b0;
    end

    // A new recovery restarts the count before this cycle's entry is added
    if ((state_q == IDLE) && recovering_i) begin
      count_base_s = 4'd0;
    end else begin
      count_base_s = count_q;
    end

    if (consume_s) begin
      rf_we_d    = (dest_reg_i != {REG_SIZE{1'b0}});
      rf_waddr_d = dest_reg_i;
      rf_wdata_d = value_i;
      epc_d      = pc_i;
      if (count_base_s != 4'd15) begin
        count_d = count_base_s + 4'd1;
      end else begin
        count_d = count_base_s;
      end
    end else begin
      count_d = count_base_s;
    end

    if ((state_q == ROLLBACK) && (state_d == REDIRECT)) begin
      redirect_d    = 1'b1;
      redirect_pc_d = mtvec_i;
    end else begin
      redirect_d    = 1'b0;
    end

    flush_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= {REG_SIZE{1'b0}};
      rf_wdata_q    <= {WORD_SIZE{1'b0}};
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= {ADDR_SIZE{1'b0}};
      epc_q         <= {ADDR_SIZE{1'b0}};
      count_q       <= 4'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_we_o          = rf_we_q;
  assign rf_waddr_o       = rf_waddr_q;
  assign rf_wdata_o       = rf_wdata_q;
  assign flush_o          = flush_q;
  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign epc_o            = epc_q;
  assign rollback_count_o = count_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_segre_rollback_unit.sv
// Directed bench for segre_rollback_unit: inputs change 1 time unit after the
// rising edge, outputs are checked there too, so each step shows the prior cycle's result.
module tb_segre_rollback_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        recovering_i = 1'b0;
  logic        hf_empty_i = 1'b1;
  logic [4:0]  dest_reg_i = 5'd0;
  logic [31:0] value_i = 32'd0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] mtvec_i = 32'd0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] epc_o;
  logic [3:0]  rollback_count_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  segre_rollback_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .recovering_i(recovering_i), .hf_empty_i(hf_empty_i),
    .dest_reg_i(dest_reg_i), .value_i(value_i), .pc_i(pc_i), .mtvec_i(mtvec_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .epc_o(epc_o), .rollback_count_o(rollback_count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic entry(input logic [4:0] d, input logic [31:0] v, input logic [31:0] p);
    recovering_i = 1'b1;
    hf_empty_i   = 1'b0;
    dest_reg_i   = d;
    value_i      = v;
    pc_i         = p;
  endtask

  task automatic drained();
    recovering_i = 1'b1;
    hf_empty_i   = 1'b1;
  endtask

  task automatic quiet();
    recovering_i = 1'b0;
    hf_empty_i   = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, {31'd0, rf_we_o}, 32'd0);
    chk({tag, "_waddr"}, {27'd0, rf_waddr_o}, 32'd0);
    chk({tag, "_wdata"}, rf_wdata_o, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_redir"}, {31'd0, redirect_o}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc_o, 32'd0);
    chk({tag, "_epc"}, epc_o, 32'd0);
    chk({tag, "_cnt"}, {28'd0, rollback_count_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we_o}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr_o}, {27'd0, a});
    chk({tag, "_wdata"}, rf_wdata_o, d);
  endtask

  initial begin
    // Reset with random inputs
    recovering_i = 1'b1;
    hf_empty_i   = 1'b0;
    dest_reg_i   = 5'($urandom);
    value_i      = $urandom;
    pc_i         = $urandom;
    mtvec_i      = $urandom;
    step();
    step();
    chk_all_zero("rst_hold");
    quiet();
    rst_i = 1'b0;
    step();
    step();
    chk_all_zero("rst_rel");

    // Three-entry rollback
    mtvec_i = 32'h0000_8000;
    entry(5'd5, 32'hAAAA_0005, 32'h100);
    step();
    chk_wr("r3_w1", 1'b1, 5'd5, 32'hAAAA_0005);
    chk("r3_flush1", {31'd0, flush_o}, 32'd1);
    chk("r3_busy1", {31'd0, busy_o}, 32'd1);
    chk("r3_redir1", {31'd0, redirect_o}, 32'd0);
    entry(5'd7, 32'h77, 32'h0FC);
    step();
    chk_wr("r3_w2", 1'b1, 5'd7, 32'h77);
    entry(5'd3, 32'h33, 32'h0F8);
    step();
    chk_wr("r3_w3", 1'b1, 5'd3, 32'h33);
    chk("r3_redir3", {31'd0, redirect_o}, 32'd0);
    drained();
    step();
    chk("r3_we4", {31'd0, rf_we_o}, 32'd0);
    chk("r3_redir4", {31'd0, redirect_o}, 32'd1);
    chk("r3_rpc", redirect_pc_o, 32'h8000);
    chk("r3_epc", epc_o, 32'h0F8);
    chk("r3_cnt", {28'd0, rollback_count_o}, 32'd3);
    chk("r3_flush4", {31'd0, flush_o}, 32'd1);
    quiet();
    step();
    chk("r3_redir5", {31'd0, redirect_o}, 32'd0);
    chk("r3_flush5", {31'd0, flush_o}, 32'd0);
    chk("r3_busy5", {31'd0, busy_o}, 32'd0);
    chk("r3_rpc_hold", redirect_pc_o, 32'h8000);

    // Stray entries without recovering_i are ignored
    recovering_i = 1'b0;
    hf_empty_i   = 1'b0;
    dest_reg_i   = 5'd9;
    step();
    chk("stray_we", {31'd0, rf_we_o}, 32'd0);
    chk("stray_busy", {31'd0, busy_o}, 32'd0);

    // x0 suppression
    entry(5'd9, 32'h99, 32'h1FC);
    step();
    chk_wr("x0_w1", 1'b1, 5'd9, 32'h99);
    entry(5'd0, 32'h123, 32'h200);
    step();
    chk("x0_we2", {31'd0, rf_we_o}, 32'd0);
    drained();
    step();
    chk("x0_we3", {31'd0, rf_we_o}, 32'd0);
    chk("x0_redir", {31'd0, redirect_o}, 32'd1);
    chk("x0_epc", epc_o, 32'h200);
    chk("x0_cnt", {28'd0, rollback_count_o}, 32'd2);
    quiet();
    step();

    // Zero-entry recovery
    mtvec_i = 32'h0000_9000;
    drained();
    step();
    chk("z_flush", {31'd0, flush_o}, 32'd1);
    chk("z_we1", {31'd0, rf_we_o}, 32'd0);
    chk("z_redir1", {31'd0, redirect_o}, 32'd0);
    chk("z_cnt1", {28'd0, rollback_count_o}, 32'd0);
    step();
    chk("z_redir2", {31'd0, redirect_o}, 32'd1);
    chk("z_rpc", redirect_pc_o, 32'h9000);
    chk("z_we2", {31'd0, rf_we_o}, 32'd0);
    chk("z_epc", epc_o, 32'h200);
    chk("z_cnt", {28'd0, rollback_count_o}, 32'd0);
    quiet();
    step();
    chk("z_busy", {31'd0, busy_o}, 32'd0);

    // Reset asserted mid-rollback, after the second of four writes
    entry(5'd10, 32'hA0, 32'h2F0);
    step();
    entry(5'd11, 32'hB0, 32'h2EC);
    step();
    chk_wr("mr_w2", 1'b1, 5'd11, 32'hB0);
    entry(5'd12, 32'hC0, 32'h2E8);
    rst_i = 1'b1;
    #1;
    chk_all_zero("mr_async");
    step();
    quiet();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_noredir", {31'd0, redirect_o}, 32'd0);
      chk("mr_nowe", {31'd0, rf_we_o}, 32'd0);
      chk("mr_busy", {31'd0, busy_o}, 32'd0);
    end
    mtvec_i = 32'h0000_A000;
    entry(5'd1, 32'h11, 32'h300);
    step();
    chk_wr("f1_w1", 1'b1, 5'd1, 32'h11);
    chk("f1_flush", {31'd0, flush_o}, 32'd1);
    drained();
    step();
    chk("f1_redir", {31'd0, redirect_o}, 32'd1);
    chk("f1_rpc", redirect_pc_o, 32'hA000);
    chk("f1_epc", epc_o, 32'h300);
    chk("f1_cnt", {28'd0, rollback_count_o}, 32'd1);
    quiet();
    step();

    // Twenty-entry recovery saturates the count
    mtvec_i = 32'h0000_B000;
    for (int i = 0; i < 20; i++) begin
      entry(5'((i % 31) + 1), 32'(i), 32'h400 + 32'(4 * i));
      step();
      chk("sat_we", {31'd0, rf_we_o}, 32'd1);
      chk("sat_wdata", rf_wdata_o, 32'(i));
      chk("sat_redir", {31'd0, redirect_o}, 32'd0);
      chk("sat_cnt", {28'd0, rollback_count_o}, (i < 15) ? 32'(i + 1) : 32'd15);
    end
    drained();
    step();
    chk("sat_redir_end", {31'd0, redirect_o}, 32'd1);
    chk("sat_cnt_end", {28'd0, rollback_count_o}, 32'd15);
    chk("sat_epc", epc_o, 32'h44C);

    // Back-to-back: REDIRECT cycle now, new recovery in the following IDLE cycle
    drained();
    step();
    chk("b2b_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("b2b_idle_redir", {31'd0, redirect_o}, 32'd0);
    entry(5'd2, 32'h22, 32'h500);
    step();
    chk_wr("b2b_w1", 1'b1, 5'd2, 32'h22);
    chk("b2b_cnt1", {28'd0, rollback_count_o}, 32'd1);
    chk("b2b_busy", {31'd0, busy_o}, 32'd1);
    entry(5'd4, 32'h44, 32'h504);
    step();
    chk_wr("b2b_w2", 1'b1, 5'd4, 32'h44);
    chk("b2b_cnt2", {28'd0, rollback_count_o}, 32'd2);
    drained();
    step();
    chk("b2b_redir", {31'd0, redirect_o}, 32'd1);
    chk("b2b_cnt", {28'd0, rollback_count_o}, 32'd2);
    chk("b2b_epc", epc_o, 32'h504);
    quiet();
    step();
    chk("b2b_end_busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
